// File: rtl/ram_copy_engine_if.sv
// Control and RAM port-B signals of the copy engine.
// The master modport is the engine side; slave is the control/RAM side.
interface ram_copy_engine_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 10
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic [ADDR_WIDTH-1:0] length;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_q;

   modport master (
      input  start, src_addr, dst_addr, length, mem_q,
      output busy, done, mem_addr, mem_data, mem_we
   );

   modport slave (
      output start, src_addr, dst_addr, length, mem_q,
      input  busy, done, mem_addr, mem_data, mem_we
   );
endinterface

// File: rtl/ram_copy_engine.sv
// Serial RAM block copier: read a word, wait for registered read data,
// write it, advance. Ascending order, addresses wrap modulo 2^ADDR_WIDTH.
module ram_copy_engine #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                clk,
   input  logic                reset,
   ram_copy_engine_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_WAIT   = 3'd2,
      S_WRITE  = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] src, src_d;
   logic [ADDR_WIDTH-1:0] dst, dst_d;
   logic [ADDR_WIDTH-1:0] remaining, remaining_d;
   logic                  busy_r, busy_d;
   logic                  done_r, done_d;
   logic                  we_r, we_d;
   logic [ADDR_WIDTH-1:0] addr_r, addr_d;
   logic [DATA_WIDTH-1:0] data_r, data_d;

   // State, counters and every output are flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         src       <= '0;
         dst       <= '0;
         remaining <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= '0;
         data_r    <= '0;
      end else begin
         state     <= state_d;
         src       <= src_d;
         dst       <= dst_d;
         remaining <= remaining_d;
         busy_r    <= busy_d;
         done_r    <= done_d;
         we_r      <= we_d;
         addr_r    <= addr_d;
         data_r    <= data_d;
      end
   end

   // Next state plus next value of each registered output.
   always_comb begin
      state_d     = state;
      src_d       = src;
      dst_d       = dst;
      remaining_d = remaining;
      busy_d      = busy_r;
      done_d      = 1'b0;
      we_d        = 1'b0;
      addr_d      = addr_r;
      data_d      = data_r;

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               src_d       = bus.src_addr;
               dst_d       = bus.dst_addr;
               remaining_d = bus.length;
               if (bus.length == '0) begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_READ;
                  busy_d  = 1'b1;
                  addr_d  = bus.src_addr;
               end
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Address still held here, so mem_q reflects the source word.
            data_d  = bus.mem_q;
            addr_d  = dst;
            we_d    = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            src_d       = src + ADDR_WIDTH'(1);
            dst_d       = dst + ADDR_WIDTH'(1);
            remaining_d = remaining - ADDR_WIDTH'(1);
            if (remaining == ADDR_WIDTH'(1)) begin
               state_d = S_FINISH;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = S_READ;
               addr_d  = src + ADDR_WIDTH'(1);
            end
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.mem_we   = we_r;
   assign bus.mem_addr = addr_r;
   assign bus.mem_data = data_r;

endmodule
